// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock,
// valid/ready handshake on both operand and result sides.
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [DIVISOR_W-1:0]    prem_q;
  logic [DIVIDEND_W-1:0]   qreg_q;
  logic [DIVISOR_W-1:0]    dsr_q;
  logic [DIVIDEND_W-1:0]   quotient_q;
  logic [DIVISOR_W-1:0]    remainder_q;
  logic                    dbz_q;

  logic [DIVISOR_W:0]      shift_d;
  logic [DIVISOR_W:0]      diff_d;
  logic                    ge_d;
  logic [DIVISOR_W-1:0]    prem_d;
  logic [DIVIDEND_W-1:0]   qreg_d;

  // The held remainder is always < divisor, so only the
  // shifted working value needs the extra bit.
  always_comb begin
    shift_d = {prem_q, qreg_q[DIVIDEND_W-1]};
    diff_d  = shift_d - {1'b0, dsr_q};
    ge_d    = shift_d >= {1'b0, dsr_q};
    prem_d  = ge_d ? diff_d[DIVISOR_W-1:0]
                   : shift_d[DIVISOR_W-1:0];
    qreg_d  = {qreg_q[DIVIDEND_W-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      qreg_q      <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              state_q <= BUSY;
              cnt_q   <= CW'(DIVIDEND_W);
              prem_q  <= '0;
              qreg_q  <= dividend;
              dsr_q   <= divisor;
            end else begin
              state_q     <= DONE;
              quotient_q  <= '1;
              remainder_q <= dividend[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
            end
          end
        end
        BUSY: begin
          prem_q <= prem_d;
          qreg_q <= qreg_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            quotient_q  <= qreg_d;
            remainder_q <= prem_d;
            dbz_q       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, corner
// sequences and a randomized scoreboard run.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  ds;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  ds;
  } op_t;

  vec_t vecs[7];
  op_t  sb[$];
  int   n_acc = 0;
  int   n_res = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // One cycle: observe handshakes at the negedge (inputs are
  // stable then), advance past the posedge, randomize stalls.
  task automatic step();
    op_t         o;
    logic [15:0] eq;
    logic [7:0]  er;
    logic [31:0] recon;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("rnd_spurious_result", 1, 0);
      end else begin
        o = sb.pop_front();
        if (o.ds == 0) begin
          eq = 16'hFFFF;
          er = o.dd[7:0];
        end else begin
          eq = o.dd / {8'd0, o.ds};
          er = 8'(o.dd % {8'd0, o.ds});
        end
        chk("rnd_quotient", quotient, eq);
        chk("rnd_remainder", remainder, er);
        chk("rnd_dbz", div_by_zero, (o.ds == 0));
        if (o.ds != 0) begin
          recon = quotient * o.ds + remainder;
          chk("rnd_invariant", recon, o.dd);
          chk("rnd_rem_lt_div", remainder < o.ds, 1);
        end
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      sb.push_back('{dd: dividend, ds: divisor});
    end
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one operation and counts edges after the
  // acceptance edge until out_valid is seen.
  task automatic run_op(input logic [15:0] dd,
                        input logic [7:0] ds,
                        output int lat);
    chk("in_ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = ds;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~dd;
    divisor  = ~ds;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] hq;
    logic [7:0]  hr;

    vecs[0] = '{16'd50000, 8'd7,   16'd7142,  8'd6,    1'b0, 16};
    vecs[1] = '{16'd65025, 8'd255, 16'd255,   8'd0,    1'b0, 16};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 16};
    vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,    1'b0, 16};
    vecs[4] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0, 16};
    vecs[5] = '{16'h04D2,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 0};
    vecs[6] = '{16'd1000,  8'd3,   16'd333,   8'd1,    1'b0, 16};

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].dd, vecs[i].ds, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_handoff_ov", i), out_valid, 0);
      chk($sformatf("vec%0d_handoff_ir", i), in_ready, 1);
    end

    // Backpressure with operand noise while the result waits
    out_ready = 1'b0;
    run_op(16'd50000, 8'd7, lat);
    chk("bp_latency", lat, 16);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_quotient", quotient, 7142);
      chk("bp_remainder", remainder, 6);
      chk("bp_dbz", div_by_zero, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_ov", out_valid, 0);
    chk("bp_handoff_ir", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept_ov", out_valid, 0);
    chk("bp_no_accept_ir", in_ready, 1);

    // Reset while busy discards the operation
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy_ir", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ir", in_ready, 1);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    run_op(16'd1000, 8'd3, lat);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_quotient", quotient, 333);
    chk("post_rst_remainder", remainder, 1);
    hq = quotient;
    hr = remainder;
    @(posedge clk);
    #1;
    chk("post_rst_handoff_ov", out_valid, 0);
    chk("post_rst_hold_q", quotient, hq);
    chk("post_rst_hold_r", remainder, hr);

    // Random regression against the arithmetic model
    for (int n = 0; n < 1000; n++) begin
      bit acc;
      int w;
      in_valid = 1'b1;
      case ($urandom_range(0, 9))
        0: dividend = 16'hFFFF;
        1: dividend = 16'h0000;
        default: dividend = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: divisor = 8'd0;
        1: divisor = 8'd1;
        2: divisor = 8'd255;
        default: divisor = 8'($urandom_range(1, 255));
      endcase
      acc = 1'b0;
      w = 0;
      while (!acc && w < 200) begin
        acc = in_ready;
        step();
        w++;
      end
      if (!acc) chk("rnd_accept_timeout", 0, 1);
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    begin
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
        step();
        w++;
      end
    end
    chk("rnd_result_count", n_res, n_acc);
    chk("rnd_accept_count", n_acc, 1000);
    chk("rnd_queue_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
